// File: rtl/usb32_polling_sequencer.sv
// usb32_polling_sequencer: USB 3.2 LTSSM Polling substate sequencer with counters and timeouts
module usb32_polling_sequencer #(
  parameter int LFPS_MIN_TX = 16,
  parameter int LFPS_MIN_RX = 2,
  parameter int TSEQ_NUM_G1 = 65536,
  parameter int TSEQ_NUM_G2 = 524288,
  parameter int TS_RX_NUM   = 8,
  parameter int TS2_TX_NUM  = 16,
  parameter int IDLE_NUM    = 8,
  parameter int T_LFPS      = 360000,
  parameter int T_ACT       = 12000,
  parameter int T_IDLE      = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_start,
  input  logic       poll_abort,
  input  logic       speed,
  input  logic       lfps_rx,
  input  logic       lfps_tx_done,
  input  logic       ts1_rx,
  input  logic       ts2_rx,
  input  logic       os_tx_done,
  input  logic       idle_rx,
  output logic [3:0] substate,
  output logic [2:0] tx_cmd,
  output logic       exit_u0,
  output logic       exit_fail,
  output logic [1:0] fail_code
);
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LFPS  = 4'd7,
    S_RXEQ  = 4'd11,
    S_ACT   = 4'd12,
    S_CFG   = 4'd13,
    S_PIDLE = 4'd14
  } state_t;
  localparam logic [19:0] LTX = 20'(LFPS_MIN_TX);
  localparam logic [19:0] G1  = 20'(TSEQ_NUM_G1);
  localparam logic [19:0] G2  = 20'(TSEQ_NUM_G2);
  localparam logic [19:0] T2  = 20'(TS2_TX_NUM);
  localparam logic [19:0] I2  = 20'(2 * IDLE_NUM);
  localparam logic [15:0] LRX = 16'(LFPS_MIN_RX);
  localparam logic [15:0] TRX = 16'(TS_RX_NUM);
  localparam logic [15:0] IRX = 16'(IDLE_NUM);
  localparam logic [31:0] TL  = 32'(T_LFPS - 2);
  localparam logic [31:0] TA  = 32'(T_ACT - 2);
  localparam logic [31:0] TI  = 32'(T_IDLE - 2);
  state_t      sub_q, sub_d;
  logic [2:0]  tx_cmd_q, tx_cmd_d;
  logic [1:0]  fail_code_q, fail_code_d;
  logic        exit_u0_q, exit_u0_d, exit_fail_q, exit_fail_d;
  logic        speed_q, speed_d, seen_q, seen_d;
  logic [19:0] tx_q, tx_d, tx_nx;
  logic [15:0] rx_q, rx_d, rx_nx;
  logic [31:0] to_q, to_d;
  logic        tx_inc, rx_inc, rx_clr, done, tmo, chg;
  always_comb begin
    tx_inc = sub_q == S_LFPS ? lfps_tx_done :
             sub_q == S_CFG ? os_tx_done & seen_q :
             (sub_q == S_RXEQ || sub_q == S_PIDLE) ? os_tx_done : 1'b0;
    rx_inc = sub_q == S_LFPS ? lfps_rx :
             sub_q == S_ACT ? ts1_rx | ts2_rx :
             sub_q == S_CFG ? ts2_rx & ~ts1_rx :
             sub_q == S_PIDLE ? idle_rx : 1'b0;
    rx_clr = sub_q == S_CFG && ts1_rx;
    tx_nx = (tx_inc && tx_q != '1) ? tx_q + 20'd1 : tx_q;
    rx_nx = rx_clr ? '0 : (rx_inc && rx_q != '1) ? rx_q + 16'd1 : rx_q;
    done = sub_q == S_LFPS ? tx_nx >= LTX && rx_nx >= LRX :
           sub_q == S_RXEQ ? tx_nx >= (speed_q ? G2 : G1) :
           sub_q == S_ACT ? rx_nx >= TRX :
           sub_q == S_CFG ? rx_nx >= TRX && tx_nx >= T2 :
           sub_q == S_PIDLE ? rx_nx >= IRX && tx_nx >= I2 : 1'b0;
    tmo = sub_q == S_LFPS ? to_q >= TL :
          (sub_q == S_ACT || sub_q == S_CFG) ? to_q >= TA :
          sub_q == S_PIDLE ? to_q >= TI : 1'b0;
    sub_d = sub_q;
    speed_d = speed_q;
    fail_code_d = fail_code_q;
    exit_u0_d = 1'b0;
    exit_fail_d = 1'b0;
    if (poll_abort) begin
      sub_d = S_IDLE;
    end else if (sub_q == S_IDLE) begin
      if (poll_start) begin
        sub_d = S_LFPS;
        speed_d = speed;
        fail_code_d = 2'd0;
      end
    end else if (done) begin
      sub_d = sub_q == S_LFPS ? S_RXEQ :
              sub_q == S_RXEQ ? S_ACT :
              sub_q == S_ACT ? S_CFG :
              sub_q == S_CFG ? S_PIDLE : S_IDLE;
      exit_u0_d = sub_q == S_PIDLE;
    end else if (tmo) begin
      sub_d = S_IDLE;
      exit_fail_d = 1'b1;
      fail_code_d = sub_q == S_LFPS ? 2'd1 : sub_q == S_PIDLE ? 2'd3 : 2'd2;
    end
    chg = sub_d != sub_q;
    tx_d = chg ? '0 : tx_nx;
    rx_d = chg ? '0 : rx_nx;
    seen_d = chg ? 1'b0 : seen_q | (sub_q == S_CFG && ts2_rx);
    to_d = (chg || sub_q == S_IDLE) ? '0 : to_q == '1 ? to_q : to_q + 32'd1;
    tx_cmd_d = sub_d == S_LFPS ? 3'd1 :
               sub_d == S_RXEQ ? 3'd2 :
               sub_d == S_ACT ? 3'd3 :
               sub_d == S_CFG ? 3'd4 :
               sub_d == S_PIDLE ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= S_IDLE;
      tx_cmd_q <= '0;
      fail_code_q <= '0;
      exit_u0_q <= 1'b0;
      exit_fail_q <= 1'b0;
      speed_q <= 1'b0;
      seen_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      to_q <= '0;
    end else begin
      sub_q <= sub_d;
      tx_cmd_q <= tx_cmd_d;
      fail_code_q <= fail_code_d;
      exit_u0_q <= exit_u0_d;
      exit_fail_q <= exit_fail_d;
      speed_q <= speed_d;
      seen_q <= seen_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      to_q <= to_d;
    end
  end
  assign substate = sub_q;
  assign tx_cmd = tx_cmd_q;
  assign exit_u0 = exit_u0_q;
  assign exit_fail = exit_fail_q;
  assign fail_code = fail_code_q;
endmodule

// File: tb/tb_usb32_polling_sequencer.sv
// tb_usb32_polling_sequencer: scoreboard bench for the Polling sequencer
module tb_usb32_polling_sequencer;
  localparam logic [7:0] START = 8'h80, ABORT = 8'h40, LRX = 8'h20, LTX = 8'h10;
  localparam logic [7:0] TS1 = 8'h08, TS2 = 8'h04, OS = 8'h02, IRX = 8'h01;
  typedef struct {
    logic [3:0] sub;
    logic [2:0] cmd;
    logic       u0;
    logic       fl;
    logic [1:0] fc;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, speed = 1'b0;
  logic poll_start = 1'b0, poll_abort = 1'b0, lfps_rx = 1'b0, lfps_tx_done = 1'b0;
  logic ts1_rx = 1'b0, ts2_rx = 1'b0, os_tx_done = 1'b0, idle_rx = 1'b0;
  logic [3:0] substate;
  logic [2:0] tx_cmd;
  logic       exit_u0, exit_fail;
  logic [1:0] fail_code;
  logic [3:0] last_sub = 4'd0;
  logic       mon_en = 1'b0;
  int checks = 0, errors = 0;
  ev_t sb[$];
  usb32_polling_sequencer #(
    .LFPS_MIN_TX(4), .LFPS_MIN_RX(2), .TSEQ_NUM_G1(8), .TSEQ_NUM_G2(16),
    .TS_RX_NUM(8), .TS2_TX_NUM(16), .IDLE_NUM(8),
    .T_LFPS(100), .T_ACT(200), .T_IDLE(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .poll_start(poll_start), .poll_abort(poll_abort),
    .speed(speed), .lfps_rx(lfps_rx), .lfps_tx_done(lfps_tx_done),
    .ts1_rx(ts1_rx), .ts2_rx(ts2_rx), .os_tx_done(os_tx_done), .idle_rx(idle_rx),
    .substate(substate), .tx_cmd(tx_cmd), .exit_u0(exit_u0),
    .exit_fail(exit_fail), .fail_code(fail_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic exp_ev(input logic [3:0] s, input logic [2:0] c, input logic u, input logic f, input logic [1:0] fc);
    ev_t e;
    e.sub = s;
    e.cmd = c;
    e.u0 = u;
    e.fl = f;
    e.fc = fc;
    sb.push_back(e);
  endtask
  task automatic step(input logic [7:0] m);
    {poll_start, poll_abort, lfps_rx, lfps_tx_done, ts1_rx, ts2_rx, os_tx_done, idle_rx} = m;
    @(posedge clk);
    #1;
    {poll_start, poll_abort, lfps_rx, lfps_tx_done, ts1_rx, ts2_rx, os_tx_done, idle_rx} = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(8'h00);
  endtask
  task automatic start(input logic sp);
    speed = sp;
    exp_ev(4'd7, 3'd1, 1'b0, 1'b0, 2'd0);
    step(START);
  endtask
  task automatic lfps();
    step(LTX | LRX);
    step(LTX | LRX);
    step(LTX);
    exp_ev(4'd11, 3'd2, 1'b0, 1'b0, 2'd0);
    step(LTX);
  endtask
  task automatic rxeq(input int n);
    repeat (n - 1) step(OS);
    exp_ev(4'd12, 3'd3, 1'b0, 1'b0, 2'd0);
    step(OS);
  endtask
  task automatic active();
    repeat (7) step(TS1);
    exp_ev(4'd13, 3'd4, 1'b0, 1'b0, 2'd0);
    step(TS1);
  endtask
  always @(negedge clk) begin
    if (mon_en && (substate !== last_sub || exit_u0 !== 1'b0 || exit_fail !== 1'b0)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_sub", substate, e.sub);
        chk("ev_cmd", tx_cmd, e.cmd);
        chk("ev_u0", exit_u0, e.u0);
        chk("ev_fail", exit_fail, e.fl);
        chk("ev_fc", fail_code, e.fc);
      end
    end
    last_sub = substate;
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sub", substate, 0);
    chk("rst_cmd", tx_cmd, 0);
    chk("rst_u0", exit_u0, 0);
    chk("rst_fail", exit_fail, 0);
    chk("rst_fc", fail_code, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);
    start(1'b0);
    lfps();
    rxeq(8);
    active();
    repeat (8) step(TS2);
    repeat (15) step(OS);
    exp_ev(4'd14, 3'd5, 1'b0, 1'b0, 2'd0);
    step(OS);
    repeat (8) step(IRX);
    repeat (15) step(OS);
    exp_ev(4'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    step(OS);
    idle(3);
    start(1'b1);
    lfps();
    repeat (8) step(OS);
    speed = 1'b0;
    repeat (7) step(OS);
    chk("gen2_hold", substate, 11);
    exp_ev(4'd12, 3'd3, 1'b0, 1'b0, 2'd0);
    step(OS);
    exp_ev(4'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst_mid_sub", substate, 0);
    idle(2);
    start(1'b0);
    step(LTX | LRX);
    repeat (3) step(LTX);
    idle(40);
    step(START);
    idle(53);
    chk("lfps_pre_tmo", substate, 7);
    exp_ev(4'd0, 3'd0, 1'b0, 1'b1, 2'd1);
    step(8'h00);
    chk("lfps_tmo_sub", substate, 0);
    chk("lfps_tmo_fail", exit_fail, 1);
    chk("lfps_tmo_fc", fail_code, 1);
    step(8'h00);
    chk("lfps_fail_pulse", exit_fail, 0);
    chk("lfps_fc_hold", fail_code, 1);
    idle(2);
    start(1'b0);
    lfps();
    rxeq(8);
    active();
    repeat (7) step(TS2);
    repeat (16) step(OS);
    step(TS1);
    repeat (7) step(TS2);
    chk("cfg_hold", substate, 13);
    exp_ev(4'd14, 3'd5, 1'b0, 1'b0, 2'd0);
    step(TS2);
    idle(33);
    repeat (8) step(IRX | OS);
    repeat (7) step(OS);
    exp_ev(4'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    step(OS);
    chk("tie_u0", exit_u0, 1);
    chk("tie_fail", exit_fail, 0);
    chk("tie_fc", fail_code, 0);
    idle(2);
    start(1'b0);
    lfps();
    rxeq(8);
    exp_ev(4'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    step(ABORT | START);
    idle(3);
    chk("abort_sub", substate, 0);
    chk("abort_fc", fail_code, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
